// File: rtl/spi_ram_slave_ctrl.sv
// SPI slave front-end sequencing a 256x8 single-port RAM.
// Optional build macro CMD_CHECK_EN: verify frame command against state.
module spi_ram_slave_ctrl #(
    parameter int TX_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       cmd_err
);

    localparam int WW = $clog2(TX_WAIT_MAX + 1) + 1;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t          state;
    logic            rd_addr_seen;
    logic [3:0]      bit_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [8:0]      shreg;
    logic [7:0]      tx_sh;
    logic [3:0]      tx_cnt;
    logic            rd_wait;
    logic [9:0]      frame;
    logic            cmd_ok;

    assign frame = {shreg, mosi};

    always_comb begin
        cmd_ok = 1'b1;
`ifdef CMD_CHECK_EN
        unique case (state)
            WRITE:     cmd_ok = ~frame[9];
            READ_ADD:  cmd_ok = (frame[9:8] == 2'b10);
            READ_DATA: cmd_ok = (frame[9:8] == 2'b11);
            default:   cmd_ok = 1'b1;
        endcase
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            miso         <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            cmd_err      <= 1'b0;
            rd_addr_seen <= 1'b0;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
            shreg        <= '0;
            tx_sh        <= '0;
            tx_cnt       <= '0;
            rd_wait      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            cmd_err  <= 1'b0;
            if (state != IDLE && ss_n) begin
                // Deselect always wins, even over a completing bit.
                state    <= IDLE;
                miso     <= 1'b0;
                bit_cnt  <= '0;
                wait_cnt <= '0;
                tx_cnt   <= '0;
                rd_wait  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        miso    <= 1'b0;
                        bit_cnt <= '0;
                        if (!ss_n) state <= CHK_CMD;
                    end
                    CHK_CMD: begin
                        if (!mosi)             state <= WRITE;
                        else if (rd_addr_seen) state <= READ_DATA;
                        else                   state <= READ_ADD;
                    end
                    default: begin
                        if (bit_cnt != 4'd10) begin
                            shreg   <= frame[8:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd9) begin
                                rx_data  <= frame;
                                rx_valid <= cmd_ok;
                                cmd_err  <= ~cmd_ok;
                                if (cmd_ok && state == READ_ADD)
                                    rd_addr_seen <= 1'b1;
                                if (cmd_ok && state == READ_DATA)
                                    rd_wait <= 1'b1;
                            end
                        end else if (rd_wait) begin
                            if (tx_valid) begin
                                miso     <= tx_data[7];
                                tx_sh    <= {tx_data[6:0], 1'b0};
                                tx_cnt   <= 4'd8;
                                rd_wait  <= 1'b0;
                                wait_cnt <= '0;
                            end else if (wait_cnt == WW'(TX_WAIT_MAX)) begin
                                state    <= IDLE;
                                miso     <= 1'b0;
                                rd_wait  <= 1'b0;
                                wait_cnt <= '0;
                                bit_cnt  <= '0;
                            end else begin
                                wait_cnt <= wait_cnt + WW'(1);
                            end
                        end else if (tx_cnt > 4'd1) begin
                            miso   <= tx_sh[7];
                            tx_sh  <= {tx_sh[6:0], 1'b0};
                            tx_cnt <= tx_cnt - 4'd1;
                        end else if (tx_cnt == 4'd1) begin
                            // Last bit has been on the line a full cycle.
                            miso         <= 1'b0;
                            tx_cnt       <= '0;
                            rd_addr_seen <= 1'b0;
                        end else begin
                            miso <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_slave_ctrl.sv
// Bench for spi_ram_slave_ctrl: frame-level reference model,
// directed vector table plus randomized frames.
module tb_spi_ram_slave_ctrl;

    localparam int TX_WAIT_MAX = 15;
`ifdef CMD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       cmd_err;

    int checks = 0;
    int failures = 0;
    bit m_seen = 1'b0;

    always #5 clk = ~clk;

    spi_ram_slave_ctrl #(.TX_WAIT_MAX(TX_WAIT_MAX)) dut (
        .clk(clk),
        .rst(rst),
        .ss_n(ss_n),
        .mosi(mosi),
        .miso(miso),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .cmd_err(cmd_err)
    );

    typedef struct {
        bit         sel;
        logic [9:0] bits;
        int         len;
        int         txd;
        logic [7:0] txb;
        int         rst_e;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // 0 = write, 1 = read address, 2 = read data
    function automatic int frame_mode(input bit sel, input bit seen);
        return !sel ? 0 : (seen ? 2 : 1);
    endfunction

    function automatic bit frame_ok(input int mode, input logic [9:0] b);
        if (!CHK) return 1'b1;
        if (mode == 0) return !b[9];
        if (mode == 1) return b[9:8] == 2'b10;
        return b[9:8] == 2'b11;
    endfunction

    // Edge k: ss_n low while k < len; selector at edge 1; bits at 2..11.
    task automatic run_frame(input vec_t v);
        bit e_miso [64];
        bit e_rv [64];
        bit e_err [64];
        int mode;
        bit ok;
        bit complete;
        bit new_seen;
        int t;
        for (int i = 0; i < 64; i++) begin
            e_miso[i] = 1'b0;
            e_rv[i]   = 1'b0;
            e_err[i]  = 1'b0;
        end
        mode     = frame_mode(v.sel, m_seen);
        ok       = frame_ok(mode, v.bits);
        complete = (v.len >= 12);
        new_seen = m_seen;
        if (complete) begin
            e_rv[11]  = ok;
            e_err[11] = !ok;
            if (ok && mode == 1) new_seen = 1'b1;
            if (ok && mode == 2 && v.txd >= 1 && v.txd <= TX_WAIT_MAX + 1) begin
                t = 11 + v.txd;
                for (int i = 0; i < 8; i++) e_miso[t + i] = v.txb[7 - i];
                new_seen = 1'b0;
            end
        end
        for (int k = 0; k <= v.len + 1; k++) begin
            ss_n = (k < v.len) ? 1'b0 : 1'b1;
            if (k == 1)
                mosi = v.sel;
            else if (k >= 2 && k <= 11)
                mosi = v.bits[11 - k];
            else
                mosi = 1'($urandom);
            tx_valid = (v.txd > 0 && k == 11 + v.txd);
            tx_data  = tx_valid ? v.txb : 8'($urandom);
            @(posedge clk);
            #1;
            check("miso", miso, e_miso[k]);
            check("rx_valid", rx_valid, e_rv[k]);
            check("cmd_err", cmd_err, e_err[k]);
            if (e_rv[k]) check("rx_data", rx_data, v.bits);
            if (k == v.rst_e) begin
                rst = 1'b1;
                #1;
                check("rst_miso", miso, 0);
                check("rst_rx_valid", rx_valid, 0);
                check("rst_rx_data", rx_data, 0);
                check("rst_cmd_err", cmd_err, 0);
                ss_n     = 1'b1;
                tx_valid = 1'b0;
                #1;
                rst      = 1'b0;
                new_seen = 1'b0;
                break;
            end
        end
        ss_n     = 1'b1;
        tx_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_miso", miso, 0);
        check("idle_rx_valid", rx_valid, 0);
        m_seen = new_seen;
    endtask

    initial begin
        vec_t tbl [16];
        vec_t r;
        int   mode;

        tbl[0]  = '{1'b0, 10'h03C, 14, 0,  8'h00, -1};
        tbl[1]  = '{1'b0, 10'h1A5, 14, 3,  8'h11, -1};
        tbl[2]  = '{1'b1, 10'h23C, 14, 0,  8'h00, -1};
        tbl[3]  = '{1'b1, 10'h3C0, 23, 2,  8'hA5, -1};
        tbl[4]  = '{1'b0, 10'h155, 7,  0,  8'h00, -1};
        tbl[5]  = '{1'b0, 10'h0F0, 14, 0,  8'h00, -1};
        tbl[6]  = '{1'b0, 10'h2AA, 11, 0,  8'h00, -1};
        tbl[7]  = '{1'b1, 10'h2AA, 14, 0,  8'h00, -1};
        tbl[8]  = '{1'b1, 10'h3AA, 29, 17, 8'hFF, -1};
        tbl[9]  = '{1'b1, 10'h355, 36, 16, 8'h96, -1};
        tbl[10] = '{1'b1, 10'h211, 14, 3,  8'hFF, -1};
        tbl[11] = '{1'b1, 10'h3C3, 21, 1,  8'hFF, 14};
        tbl[12] = '{1'b1, 10'h2AB, 22, 1,  8'hFF, -1};
        tbl[13] = '{1'b1, 10'h3FF, 14, 0,  8'h00, -1};
        tbl[14] = '{1'b0, 10'h300, 14, 0,  8'h00, -1};
        tbl[15] = '{1'b1, 10'h35A, 25, 4,  8'h5A, -1};

        #2;
        check("reset_miso", miso, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_cmd_err", cmd_err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) run_frame(tbl[i]);

        for (int n = 0; n < 40; n++) begin
            r.sel   = 1'($urandom);
            r.bits  = 10'($urandom);
            mode    = frame_mode(r.sel, m_seen);
            if ($urandom_range(0, 3) != 0) begin
                if (mode == 0)      r.bits[9]   = 1'b0;
                else if (mode == 1) r.bits[9:8] = 2'b10;
                else                r.bits[9:8] = 2'b11;
            end
            r.txd   = $urandom_range(0, 18);
            r.txb   = 8'($urandom);
            r.rst_e = -1;
            if ($urandom_range(0, 5) == 0)
                r.len = $urandom_range(2, 11);
            else if (mode == 2 && frame_ok(mode, r.bits) &&
                     r.txd >= 1 && r.txd <= TX_WAIT_MAX + 1)
                r.len = 20 + r.txd + $urandom_range(0, 2);
            else if (mode == 2)
                r.len = $urandom_range(12, 29);
            else
                r.len = $urandom_range(12, 20);
            run_frame(r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
